// File: rtl/game_master.sv
// rtl/game_master.sv - tetris placement host: piece generation, advice handshake, placement and line clears
// board_nextsim drops the advised piece one row per cycle and returns the merged board.

module board_nextsim (
  input  logic         clk,
  input  logic         rst,
  input  logic         sim_request,
  input  logic [3:0]   block,
  input  logic [3:0]   col,
  input  logic [1:0]   rot,
  input  logic [199:0] board_in,
  output logic         sim_ready,
  output logic         sim_valid,
  output logic [199:0] sim_board
);
  logic         active;
  logic [4:0]   drop_row;
  logic [15:0]  mask_q;
  logic [3:0]   col_q;
  logic [199:0] board_q;
  logic         fit_now;
  logic         fit_next;

  // 4x4 occupancy mask, bit 4*row+col, anchored at the top-left of the bounding box
  function automatic logic [15:0] shape(input logic [3:0] b, input logic [1:0] r);
    case (b)
      4'd0: shape = r[0] ? 16'h1111 : 16'h000F;
      4'd2: shape = (r == 2'd0) ? 16'h0027 : (r == 2'd1) ? 16'h0232 : (r == 2'd2) ? 16'h0072 : 16'h0131;
      4'd3: shape = r[0] ? 16'h0231 : 16'h0036;
      4'd4: shape = r[0] ? 16'h0132 : 16'h0063;
      4'd5: shape = (r == 2'd0) ? 16'h0071 : (r == 2'd1) ? 16'h0113 : (r == 2'd2) ? 16'h0047 : 16'h0322;
      4'd6: shape = (r == 2'd0) ? 16'h0074 : (r == 2'd1) ? 16'h0311 : (r == 2'd2) ? 16'h0017 : 16'h0223;
      default: shape = 16'h0033;
    endcase
  endfunction

  function automatic logic fits(input logic [199:0] b, input logic [15:0] m, input int y, input int x);
    int rr;
    int cc;
    fits = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rr = y + i / 4;
      cc = x + i % 4;
      if (m[i] && (rr > 19 || cc > 9)) fits = 1'b0;
      else if (m[i] && b[8'(rr * 10 + cc)]) fits = 1'b0;
    end
  endfunction

  function automatic logic [199:0] place(input logic [199:0] b, input logic [15:0] m, input int y, input int x);
    place = b;
    for (int i = 0; i < 16; i++)
      if (m[i]) place[8'((y + i / 4) * 10 + x + i % 4)] = 1'b1;
  endfunction

  assign fit_now  = fits(board_q, mask_q, int'(drop_row), int'(col_q));
  assign fit_next = fits(board_q, mask_q, int'(drop_row) + 1, int'(col_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      drop_row  <= '0;
      mask_q    <= '0;
      col_q     <= '0;
      board_q   <= '0;
      sim_ready <= 1'b0;
      sim_valid <= 1'b0;
      sim_board <= '0;
    end else begin
      sim_ready <= 1'b0;
      if (sim_request) begin
        active   <= 1'b1;
        drop_row <= '0;
        mask_q   <= shape(block, rot);
        col_q    <= col;
        board_q  <= board_in;
      end else if (active) begin
        if (!fit_now) begin
          active    <= 1'b0;
          sim_ready <= 1'b1;
          sim_valid <= 1'b0;
        end else if (fit_next) begin
          drop_row <= drop_row + 5'd1;
        end else begin
          active    <= 1'b0;
          sim_ready <= 1'b1;
          sim_valid <= 1'b1;
          sim_board <= place(board_q, mask_q, int'(drop_row), int'(col_q));
        end
      end
    end
  end
endmodule

module game_master #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          SPAWN_ROWS     = 2,
  parameter int          MAX_PIECES     = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         req_to_client,
  output logic [3:0]   cur_block,
  output logic [199:0] cur_board,
  input  logic         resp_from_client,
  input  logic [3:0]   opt_col,
  input  logic [1:0]   opt_rotation,
  output logic         busy,
  output logic         game_over,
  output logic         piece_done,
  output logic [15:0]  lines_cleared,
  output logic [15:0]  pieces_placed
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] SPAWN       = 4'd1;
  localparam logic [3:0] REQ         = 4'd2;
  localparam logic [3:0] WAIT_RESP   = 4'd3;
  localparam logic [3:0] SIM_REQ     = 4'd4;
  localparam logic [3:0] SIM_WAIT    = 4'd5;
  localparam logic [3:0] CLEAR_SCAN  = 4'd6;
  localparam logic [3:0] CLEAR_SHIFT = 4'd7;
  localparam logic [3:0] CHECK       = 4'd8;
  localparam logic [3:0] GAME_OVER   = 4'd9;

  logic [3:0]   state;
  logic [15:0]  lfsr;
  logic [15:0]  lfsr_next;
  logic [31:0]  tcnt;
  logic [3:0]   col_q;
  logic [1:0]   rot_q;
  logic [4:0]   row_idx;
  logic [7:0]   row_base;
  logic         row_full;
  logic         above_full;
  logic         top_busy;
  logic [199:0] shifted;
  logic         sim_request;
  logic         sim_ready;
  logic         sim_valid;
  logic [199:0] sim_board;

  assign lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign sim_request = (state == SIM_REQ);
  assign busy        = (state != IDLE) && (state != GAME_OVER);
  assign game_over   = (state == GAME_OVER);
  assign piece_done  = (state == CHECK);
  assign row_base    = 8'(row_idx) * 8'd10;
  assign row_full    = &cur_board[row_base +: 10];
  assign top_busy    = |cur_board[10*SPAWN_ROWS-1:0];

  // The row sliding into r during a shift is checked here so a stacked clear never needs a rescan.
  always_comb begin
    above_full = 1'b0;
    if (row_idx != 5'd0) above_full = &cur_board[(row_base - 8'd10) +: 10];
  end

  always_comb begin
    shifted = cur_board;
    for (int r = 0; r < 20; r++) begin
      if (r == 0) shifted[9:0] = '0;
      else if (r <= int'(row_idx)) shifted[8'(10 * r) +: 10] = cur_board[8'(10 * (r - 1)) +: 10];
    end
  end

  board_nextsim u_nextsim (
    .clk         (clk),
    .rst         (rst),
    .sim_request (sim_request),
    .block       (cur_block),
    .col         (col_q),
    .rot         (rot_q),
    .board_in    (cur_board),
    .sim_ready   (sim_ready),
    .sim_valid   (sim_valid),
    .sim_board   (sim_board)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED;
      tcnt          <= '0;
      col_q         <= '0;
      rot_q         <= '0;
      row_idx       <= '0;
      req_to_client <= 1'b0;
      cur_block     <= '0;
      cur_board     <= '0;
      lines_cleared <= '0;
      pieces_placed <= '0;
    end else begin
      case (state)
        IDLE, GAME_OVER: if (start) begin
          cur_board     <= '0;
          lines_cleared <= '0;
          pieces_placed <= '0;
          state         <= SPAWN;
        end
        SPAWN: begin
          lfsr <= lfsr_next;
          if (lfsr_next[2:0] != 3'd7) begin
            cur_block <= {1'b0, lfsr_next[2:0]};
            state     <= REQ;
          end
        end
        REQ: begin
          req_to_client <= 1'b1;
          tcnt          <= '0;
          state         <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (resp_from_client) begin
            req_to_client <= 1'b0;
            col_q         <= opt_col;
            rot_q         <= opt_rotation;
            state         <= SIM_REQ;
          end else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
            req_to_client <= 1'b0;
            state         <= GAME_OVER;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        SIM_REQ: state <= SIM_WAIT;
        SIM_WAIT: if (sim_ready) begin
          if (sim_valid) begin
            cur_board <= sim_board;
            if (pieces_placed != 16'hFFFF) pieces_placed <= pieces_placed + 16'd1;
            row_idx <= 5'd19;
            state   <= CLEAR_SCAN;
          end else begin
            state <= GAME_OVER;
          end
        end
        CLEAR_SCAN: begin
          if (row_full) state <= CLEAR_SHIFT;
          else if (row_idx == 5'd0) state <= CHECK;
          else row_idx <= row_idx - 5'd1;
        end
        CLEAR_SHIFT: begin
          cur_board <= shifted;
          if (lines_cleared != 16'hFFFF) lines_cleared <= lines_cleared + 16'd1;
          if (above_full) state <= CLEAR_SHIFT;
          else if (row_idx == 5'd0) state <= CHECK;
          else begin
            row_idx <= row_idx - 5'd1;
            state   <= CLEAR_SCAN;
          end
        end
        CHECK: begin
          if (top_busy) state <= GAME_OVER;
          else if (MAX_PIECES != 0 && pieces_placed == 16'(MAX_PIECES)) state <= GAME_OVER;
          else state <= SPAWN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_master.sv
// tb/tb_game_master.sv - randomized self-checking bench for game_master against a grid-level tetris model
module tb_game_master;
  localparam int TO = 400;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, resp = 1'b0;
  logic [3:0]   opt_col = '0;
  logic [1:0]   opt_rotation = '0;
  logic         req, busy, game_over, piece_done;
  logic [3:0]   cur_block;
  logic [199:0] cur_board;
  logic [15:0]  lines_cleared, pieces_placed;

  game_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .req_to_client(req), .cur_block(cur_block),
    .cur_board(cur_board), .resp_from_client(resp), .opt_col(opt_col), .opt_rotation(opt_rotation),
    .busy(busy), .game_over(game_over), .piece_done(piece_done),
    .lines_cleared(lines_cleared), .pieces_placed(pieces_placed)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [15:0] m_lfsr;
  bit   mb [20][10];
  int   m_lines, m_pieces;

  // each word lists four (row, col) cells as hex digit pairs: I O T S Z J L, rotations 0..3
  int unsigned shp [7][4] = '{
    '{32'h00010203, 32'h00102030, 32'h00010203, 32'h00102030},
    '{32'h00011011, 32'h00011011, 32'h00011011, 32'h00011011},
    '{32'h00010211, 32'h01101121, 32'h01101112, 32'h00101120},
    '{32'h01021011, 32'h00101121, 32'h01021011, 32'h00101121},
    '{32'h00011112, 32'h01101120, 32'h00011112, 32'h01101120},
    '{32'h00101112, 32'h00011020, 32'h00010212, 32'h01112021},
    '{32'h02101112, 32'h00102021, 32'h00010210, 32'h00011121}
  };

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int cell_r(int p, int rot, int i);
    return int'((shp[p][rot] >> (28 - 8 * i)) & 32'hF);
  endfunction
  function automatic int cell_c(int p, int rot, int i);
    return int'((shp[p][rot] >> (24 - 8 * i)) & 32'hF);
  endfunction

  function automatic bit fits(int p, int rot, int y, int x);
    for (int i = 0; i < 4; i++) begin
      if (y + cell_r(p, rot, i) > 19 || x + cell_c(p, rot, i) > 9) return 1'b0;
      if (mb[y + cell_r(p, rot, i)][x + cell_c(p, rot, i)]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int drop_row(int p, int rot, int x);
    int y = 0;
    while (fits(p, rot, y + 1, x)) y++;
    return y;
  endfunction

  function automatic void stamp(int p, int rot, int y, int x);
    for (int i = 0; i < 4; i++) mb[y + cell_r(p, rot, i)][x + cell_c(p, rot, i)] = 1'b1;
  endfunction

  function automatic int clear_rows();
    bit nb [20][10];
    int k, dst;
    bit full;
    nb = '{default: 1'b0};
    k = 0;
    dst = 19;
    for (int src = 19; src >= 0; src--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++) full &= mb[src][c];
      if (full) k++;
      else begin
        for (int c = 0; c < 10; c++) nb[dst][c] = mb[src][c];
        dst--;
      end
    end
    mb = nb;
    return k;
  endfunction

  function automatic logic [199:0] flat();
    logic [199:0] v = '0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) v[8'(r * 10 + c)] = mb[r][c];
    return v;
  endfunction

  function automatic bit top_occ();
    bit any = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 10; c++) any |= mb[r][c];
    return any;
  endfunction

  task automatic next_piece(output int p, output int steps);
    steps = 0;
    do begin
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      steps++;
    end while (m_lfsr[2:0] == 3'd7);
    p = int'(m_lfsr[2:0]);
  endtask

  task automatic choose_greedy(input int p, output int bx, output int brot);
    bit sv [20][10];
    int best, sc, y, k, holes, rowsum, r, c;
    best = -1000000; bx = 0; brot = 0;
    for (int rot = 0; rot < 4; rot++)
      for (int x = 0; x < 10; x++)
        if (fits(p, rot, 0, x)) begin
          sv = mb;
          y = drop_row(p, rot, x);
          stamp(p, rot, y, x);
          holes = 0; rowsum = 0;
          for (int i = 0; i < 4; i++) begin
            r = y + cell_r(p, rot, i);
            c = x + cell_c(p, rot, i);
            rowsum += r;
            if (r < 19 && !mb[r + 1][c]) holes++;
          end
          k = clear_rows();
          mb = sv;
          sc = (100 * k + rowsum - 20 * holes) * 16 + int'($urandom_range(0, 15));
          if (sc > best) begin best = sc; bx = x; brot = rot; end
        end
  endtask

  task automatic start_game();
    start = 1'b1; tick(); start = 1'b0;
    mb = '{default: 1'b0}; m_lines = 0; m_pieces = 0;
    check("start_board", cur_board, flat());
    check("start_lines", lines_cleared, 16'd0);
    check("start_pieces", pieces_placed, 16'd0);
    check("start_busy", busy, 1'b1);
  endtask

  // mode 0: greedy advisor, 1: stack at column 3, 2: off-board column
  task automatic play_piece(input int mode, input bit first, input int delay, output bit over);
    int cnt, p, steps, x, rot, y, k;
    logic [15:0] old;
    over = 1'b0;
    cnt = 0;
    while (!req && cnt < 300) begin tick(); cnt++; end
    check("req_rise", req, 1'b1);
    if (!req) begin over = 1'b1; return; end
    next_piece(p, steps);
    if (first) check("spawn_latency", cnt, steps + 1);
    check("cur_block", cur_block, p);
    check("cur_board", cur_board, flat());
    check("busy", busy, 1'b1);
    case (mode)
      0: choose_greedy(p, x, rot);
      1: begin x = 3; rot = int'($urandom_range(0, 3)); end
      default: begin x = int'($urandom_range(10, 15)); rot = int'($urandom_range(0, 3)); end
    endcase
    cnt = 0;
    while (req && cnt < delay) begin tick(); cnt++; end
    check("req_hold", req, 1'b1);
    resp = 1'b1; opt_col = 4'(x); opt_rotation = 2'(rot);
    tick();
    resp = 1'b0;
    check("req_drop", req, 1'b0);
    if (!fits(p, rot, 0, x)) begin
      cnt = 0;
      while (!game_over && cnt < 60) begin tick(); cnt++; end
      check("over_invalid", game_over, 1'b1);
      check("board_kept", cur_board, flat());
      check("lines_kept", lines_cleared, m_lines);
      check("pieces_kept", pieces_placed, m_pieces);
      over = 1'b1;
      return;
    end
    y = drop_row(p, rot, x);
    stamp(p, rot, y, x);
    m_pieces++;
    k = clear_rows();
    m_lines += k;
    old = pieces_placed;
    cnt = 0;
    while (pieces_placed == old && cnt < 60) begin tick(); cnt++; end
    check("pieces_placed", pieces_placed, m_pieces);
    cnt = 0;
    while (!piece_done && cnt < 60) begin tick(); cnt++; end
    check("clear_latency", cnt, 20 + k);
    check("lines_cleared", lines_cleared, m_lines);
    check("board", cur_board, flat());
    tick();
    check("done_pulse", piece_done, 1'b0);
    check("over_top", game_over, top_occ());
    over = top_occ();
  endtask

  task automatic timeout_test();
    int cnt, p, steps;
    cnt = 0;
    while (!req && cnt < 300) begin tick(); cnt++; end
    check("to_req_rise", req, 1'b1);
    next_piece(p, steps);
    check("to_block", cur_block, p);
    cnt = 0;
    while (req && cnt < TO + 20) begin tick(); cnt++; end
    check("timeout_cycles", cnt, TO);
    check("timeout_over", game_over, 1'b1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_lines", lines_cleared, m_lines);
  endtask

  initial begin
    bit over;
    int np, cnt, p, steps;
    m_lfsr = 16'hACE1; mb = '{default: 1'b0}; m_lines = 0; m_pieces = 0;
    repeat (3) tick();
    check("rst_req", req, 1'b0);
    check("rst_block", cur_block, 4'd0);
    check("rst_board", cur_board, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_over", game_over, 1'b0);
    check("rst_done", piece_done, 1'b0);
    check("rst_lines", lines_cleared, 16'd0);
    check("rst_pieces", pieces_placed, 16'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    start_game();
    play_piece(0, 1'b1, 300, over);
    np = 1;
    while (!over && np < 24) begin
      play_piece(0, 1'b0, int'($urandom_range(0, 6)), over);
      np++;
    end
    if (over) start_game();
    timeout_test();

    start_game();
    over = 1'b0; np = 0;
    while (!over && np < 40) begin
      play_piece(1, np == 0, int'($urandom_range(0, 4)), over);
      np++;
    end
    check("stack_over", game_over, 1'b1);

    start_game();
    play_piece(2, 1'b1, 2, over);

    start_game();
    cnt = 0;
    while (!req && cnt < 300) begin tick(); cnt++; end
    check("d_req_rise", req, 1'b1);
    next_piece(p, steps);
    #3 rst = 1'b1;
    #1;
    check("arst_req", req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_block", cur_block, 4'd0);
    check("arst_pieces", pieces_placed, 16'd0);
    m_lfsr = 16'hACE1; mb = '{default: 1'b0}; m_lines = 0; m_pieces = 0;
    tick();
    rst = 1'b0;
    resp = 1'b1; opt_col = 4'd0;
    tick();
    resp = 1'b0;
    repeat (5) tick();
    check("late_resp_req", req, 1'b0);
    check("late_resp_busy", busy, 1'b0);
    check("late_resp_over", game_over, 1'b0);
    check("late_resp_pieces", pieces_placed, 16'd0);
    start_game();
    play_piece(0, 1'b1, 1, over);
    np = 1;
    while (!over && np < 4) begin
      play_piece(0, 1'b0, int'($urandom_range(0, 3)), over);
      np++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
